// File: rtl/alu_pipe_unit_pkg.sv
// Shared ALU types: operation and operand-select encodings used by decode,
// the reservation station and the ALU functional units.
package alu_pipe_unit_pkg;

  localparam int unsigned ALU_OP_W  = 4;
  localparam int unsigned ALU_SEL_W = 2;

  typedef enum logic [ALU_OP_W-1:0] {
    alu_add  = 4'd0,
    alu_sub  = 4'd1,
    alu_sll  = 4'd2,
    alu_srl  = 4'd3,
    alu_sra  = 4'd4,
    alu_xor  = 4'd5,
    alu_or   = 4'd6,
    alu_and  = 4'd7,
    alu_slt  = 4'd8,
    alu_sltu = 4'd9
  } alu_ops_t;

  typedef enum logic [ALU_SEL_W-1:0] {
    rs1_out = 2'd0,
    pc_out  = 2'd1,
    no_out  = 2'd2
  } alu_m1_sel_t;

  typedef enum logic [ALU_SEL_W-1:0] {
    rs2_out  = 2'd0,
    imm_out  = 2'd1,
    four_out = 2'd2
  } alu_m2_sel_t;

endpackage

// File: rtl/alu_pipe_unit_if.sv
// Issue-side and writeback-side handshake bundle of the ALU pipe unit.
// master = reservation station / CDB arbiter side, slave = the unit.
interface alu_pipe_unit_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned PREG_W = 6,
  parameter int unsigned ROB_W  = 5
);
  import alu_pipe_unit_pkg::*;

  logic              issue_valid;
  logic              issue_ready;
  alu_ops_t          issue_aluop;
  alu_m1_sel_t       issue_m1_sel;
  alu_m2_sel_t       issue_m2_sel;
  logic [WIDTH-1:0]  issue_rs1_data;
  logic [WIDTH-1:0]  issue_rs2_data;
  logic [WIDTH-1:0]  issue_pc;
  logic [WIDTH-1:0]  issue_imm;
  logic [PREG_W-1:0] issue_rd_paddr;
  logic [ROB_W-1:0]  issue_rob_idx;
  logic              issue_regf_we;

  logic              wb_valid;
  logic              wb_ready;
  logic [WIDTH-1:0]  wb_rd_data;
  logic [PREG_W-1:0] wb_rd_paddr;
  logic [ROB_W-1:0]  wb_rob_idx;
  logic              wb_regf_we;
  logic [WIDTH-1:0]  wb_pc;

  modport master (
    output issue_valid, issue_aluop, issue_m1_sel, issue_m2_sel,
           issue_rs1_data, issue_rs2_data, issue_pc, issue_imm,
           issue_rd_paddr, issue_rob_idx, issue_regf_we, wb_ready,
    input  issue_ready, wb_valid, wb_rd_data, wb_rd_paddr, wb_rob_idx,
           wb_regf_we, wb_pc
  );

  modport slave (
    input  issue_valid, issue_aluop, issue_m1_sel, issue_m2_sel,
           issue_rs1_data, issue_rs2_data, issue_pc, issue_imm,
           issue_rd_paddr, issue_rob_idx, issue_regf_we, wb_ready,
    output issue_ready, wb_valid, wb_rd_data, wb_rd_paddr, wb_rob_idx,
           wb_regf_we, wb_pc
  );

endinterface

// File: rtl/alu_pipe_unit_core.sv
// Combinational operand mux and integer op evaluation; shared with the branch unit.
module alu_pipe_unit_core
  import alu_pipe_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  alu_ops_t         aluop,
  input  alu_m1_sel_t      m1_sel,
  input  alu_m2_sel_t      m2_sel,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] imm,
  output logic [WIDTH-1:0] result_c
);

  localparam int unsigned SH_W = $clog2(WIDTH);

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [SH_W-1:0]  shamt;

  always_comb begin
    op_a = '0;
    op_b = '0;
    case (m1_sel)
      rs1_out: op_a = rs1_data;
      pc_out:  op_a = pc;
      default: op_a = '0;
    endcase
    case (m2_sel)
      rs2_out:  op_b = rs2_data;
      imm_out:  op_b = imm;
      four_out: op_b = WIDTH'(4);
      default:  op_b = '0;
    endcase
  end

  // Shifts only look at the low log2(WIDTH) bits of operand b.
  assign shamt = op_b[SH_W-1:0];

  always_comb begin
    result_c = '0;
    case (aluop)
      alu_add:  result_c = op_a + op_b;
      alu_sub:  result_c = op_a - op_b;
      alu_sll:  result_c = op_a << shamt;
      alu_srl:  result_c = op_a >> shamt;
      alu_sra:  result_c = WIDTH'($signed(op_a) >>> shamt);
      alu_xor:  result_c = op_a ^ op_b;
      alu_or:   result_c = op_a | op_b;
      alu_and:  result_c = op_a & op_b;
      alu_slt:  result_c = WIDTH'($signed(op_a) < $signed(op_b));
      alu_sltu: result_c = WIDTH'(op_a < op_b);
      default:  result_c = '0;
    endcase
  end

endmodule

// File: rtl/alu_pipe_unit.sv
// Pipelined ALU functional unit: compute in stage 0, carry through STAGES
// registers with valid/ready backpressure, bubble collapse and flush.
module alu_pipe_unit
  import alu_pipe_unit_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2,
  parameter int unsigned PREG_W = 6,
  parameter int unsigned ROB_W  = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  alu_pipe_unit_if.slave               bus,
  output logic [$clog2(STAGES+1)-1:0]  occupancy
);

  localparam int unsigned OCC_W = $clog2(STAGES + 1);

  typedef struct packed {
    logic [WIDTH-1:0]  result;
    logic [WIDTH-1:0]  pc;
    logic [PREG_W-1:0] rd_paddr;
    logic [ROB_W-1:0]  rob_idx;
    logic              regf_we;
  } stage_t;

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;
  logic [STAGES-1:0] accept_c;
  logic [OCC_W-1:0]  occ_d;
  logic [WIDTH-1:0]  result_c;
  stage_t            issue_rec_c;

  alu_pipe_unit_core #(.WIDTH(WIDTH)) u_core (
    .aluop    (bus.issue_aluop),
    .m1_sel   (bus.issue_m1_sel),
    .m2_sel   (bus.issue_m2_sel),
    .rs1_data (bus.issue_rs1_data),
    .rs2_data (bus.issue_rs2_data),
    .pc       (bus.issue_pc),
    .imm      (bus.issue_imm),
    .result_c (result_c)
  );

  always_comb begin
    issue_rec_c          = '0;
    issue_rec_c.result   = result_c;
    issue_rec_c.pc       = bus.issue_pc;
    issue_rec_c.rd_paddr = bus.issue_rd_paddr;
    issue_rec_c.rob_idx  = bus.issue_rob_idx;
    issue_rec_c.regf_we  = bus.issue_regf_we;
  end

  // A stage can take new data when empty or when it is itself draining;
  // the chain runs from writeback backwards so ready passes straight through.
  always_comb begin
    accept_c = '0;
    accept_c[STAGES-1] = !valid_q[STAGES-1] || bus.wb_ready;
    for (int i = int'(STAGES) - 2; i >= 0; i--) begin
      accept_c[i] = !valid_q[i] || accept_c[i+1];
    end
  end

  always_comb begin
    valid_d = valid_q;
    if (accept_c[0]) valid_d[0] = bus.issue_valid;
    for (int i = 1; i < int'(STAGES); i++) begin
      if (accept_c[i]) valid_d[i] = valid_q[i-1];
    end
    if (flush) valid_d = '0;
  end

  always_comb begin
    occ_d = '0;
    for (int i = 0; i < int'(STAGES); i++) begin
      occ_d = occ_d + OCC_W'(valid_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= '0;
      occupancy <= '0;
    end else begin
      valid_q   <= valid_d;
      occupancy <= occ_d;
    end
  end

  // Payload registers carry no reset; only the valid bits are authoritative.
  for (genvar i = 0; i < int'(STAGES); i++) begin : g_stage
    stage_t rec_q;
    if (i == 0) begin : g_head
      always_ff @(posedge clk) begin
        if (accept_c[0]) rec_q <= issue_rec_c;
      end
    end else begin : g_body
      always_ff @(posedge clk) begin
        if (accept_c[i]) rec_q <= g_stage[i-1].rec_q;
      end
    end
  end

  assign bus.issue_ready = accept_c[0];
  assign bus.wb_valid    = valid_q[STAGES-1] && !flush;
  assign bus.wb_rd_data  = g_stage[STAGES-1].rec_q.result;
  assign bus.wb_pc       = g_stage[STAGES-1].rec_q.pc;
  assign bus.wb_rd_paddr = g_stage[STAGES-1].rec_q.rd_paddr;
  assign bus.wb_rob_idx  = g_stage[STAGES-1].rec_q.rob_idx;
  assign bus.wb_regf_we  = g_stage[STAGES-1].rec_q.regf_we;

endmodule

// File: tb/tb_alu_pipe_unit.sv
// Scoreboard bench for alu_pipe_unit: STAGES=2/WIDTH=32 main instance plus
// STAGES=1/WIDTH=32 and STAGES=4/WIDTH=64 instances for latency and shifts.
module tb_alu_pipe_unit;
  import alu_pipe_unit_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int tests = 0;
  int fails = 0;

  alu_pipe_unit_if #(.WIDTH(32), .PREG_W(6), .ROB_W(5)) a_if ();
  alu_pipe_unit_if #(.WIDTH(32), .PREG_W(6), .ROB_W(5)) b_if ();
  alu_pipe_unit_if #(.WIDTH(64), .PREG_W(6), .ROB_W(5)) c_if ();
  logic [1:0] occ_a;
  logic [0:0] occ_b;
  logic [2:0] occ_c;

  alu_pipe_unit #(.WIDTH(32), .STAGES(2), .PREG_W(6), .ROB_W(5)) u_a (
    .clk(clk), .rst(rst), .flush(flush), .bus(a_if), .occupancy(occ_a));
  alu_pipe_unit #(.WIDTH(32), .STAGES(1), .PREG_W(6), .ROB_W(5)) u_b (
    .clk(clk), .rst(rst), .flush(flush), .bus(b_if), .occupancy(occ_b));
  alu_pipe_unit #(.WIDTH(64), .STAGES(4), .PREG_W(6), .ROB_W(5)) u_c (
    .clk(clk), .rst(rst), .flush(flush), .bus(c_if), .occupancy(occ_c));

  typedef struct {
    logic [31:0] data;
    logic [31:0] pc;
    logic [5:0]  rd;
    logic [4:0]  rob;
    logic        we;
    int          cyc;
    bit          chk_lat;
  } exp_a_t;

  typedef struct {
    logic [63:0] data;
    int          cyc;
  } exp_s_t;

  exp_a_t q_a[$];
  exp_s_t q_b[$];
  exp_s_t q_c[$];
  exp_a_t nxt_a, mon_a;
  exp_s_t nxt_b, nxt_c, mon_b, mon_c;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Instance A: expected response is queued at issue, popped at writeback.
  always @(negedge clk) begin
    if (!rst) begin
      if (a_if.wb_valid && a_if.wb_ready) begin
        if (q_a.size() == 0) fail_now("a_unexpected_wb");
        else begin
          mon_a = q_a.pop_front();
          check("a_data", 64'(a_if.wb_rd_data), 64'(mon_a.data));
          check("a_pc", 64'(a_if.wb_pc), 64'(mon_a.pc));
          check("a_tags", 64'({a_if.wb_rd_paddr, a_if.wb_rob_idx, a_if.wb_regf_we}),
                64'({mon_a.rd, mon_a.rob, mon_a.we}));
          if (mon_a.chk_lat) check("a_latency", 64'(cyc - mon_a.cyc), 64'd2);
        end
      end
      if (flush) q_a.delete();
      else if (a_if.issue_valid && a_if.issue_ready) begin
        mon_a = nxt_a;
        mon_a.cyc = cyc;
        q_a.push_back(mon_a);
      end
    end
  end

  // Instances B and C always run with wb_ready high, so issue_ready must be high.
  always @(negedge clk) begin
    if (!rst) begin
      if (b_if.wb_valid && b_if.wb_ready) begin
        if (q_b.size() == 0) fail_now("b_unexpected_wb");
        else begin
          mon_b = q_b.pop_front();
          check("b_data", 64'(b_if.wb_rd_data), mon_b.data);
          check("b_latency", 64'(cyc - mon_b.cyc), 64'd1);
        end
      end
      if (c_if.wb_valid && c_if.wb_ready) begin
        if (q_c.size() == 0) fail_now("c_unexpected_wb");
        else begin
          mon_c = q_c.pop_front();
          check("c_data", c_if.wb_rd_data, mon_c.data);
          check("c_latency", 64'(cyc - mon_c.cyc), 64'd4);
        end
      end
      if (b_if.issue_valid) begin
        check("b_issue_ready", 64'(b_if.issue_ready), 64'd1);
        if (b_if.issue_ready) begin
          mon_b = nxt_b;
          mon_b.cyc = cyc;
          q_b.push_back(mon_b);
        end
      end
      if (c_if.issue_valid) begin
        check("c_issue_ready", 64'(c_if.issue_ready), 64'd1);
        if (c_if.issue_ready) begin
          mon_c = nxt_c;
          mon_c.cyc = cyc;
          q_c.push_back(mon_c);
        end
      end
    end
  end

  task automatic set_a(input logic [3:0] op, input logic [1:0] m1, input logic [1:0] m2,
                       input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] pc, input logic [31:0] imm,
                       input logic [5:0] rd, input logic [4:0] rob, input logic we,
                       input logic [31:0] exp, input bit chk);
    a_if.issue_aluop    = alu_ops_t'(op);
    a_if.issue_m1_sel   = alu_m1_sel_t'(m1);
    a_if.issue_m2_sel   = alu_m2_sel_t'(m2);
    a_if.issue_rs1_data = rs1;
    a_if.issue_rs2_data = rs2;
    a_if.issue_pc       = pc;
    a_if.issue_imm      = imm;
    a_if.issue_rd_paddr = rd;
    a_if.issue_rob_idx  = rob;
    a_if.issue_regf_we  = we;
    nxt_a = '{data: exp, pc: pc, rd: rd, rob: rob, we: we, cyc: 0, chk_lat: chk};
    a_if.issue_valid    = 1'b1;
  endtask

  // Hold the op until accepted (bounded), then drop issue_valid after the edge.
  task automatic wait_ready_a();
    int n = 0;
    @(negedge clk);
    while (!a_if.issue_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!a_if.issue_ready) fail_now("a_issue_timeout");
    @(posedge clk);
    #1;
    a_if.issue_valid = 1'b0;
  endtask

  task automatic set_b(input logic [3:0] op, input logic [1:0] m2, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [31:0] imm, input logic [31:0] exp);
    b_if.issue_aluop    = alu_ops_t'(op);
    b_if.issue_m1_sel   = rs1_out;
    b_if.issue_m2_sel   = alu_m2_sel_t'(m2);
    b_if.issue_rs1_data = rs1;
    b_if.issue_rs2_data = rs2;
    b_if.issue_imm      = imm;
    nxt_b = '{data: 64'(exp), cyc: 0};
    b_if.issue_valid    = 1'b1;
  endtask

  task automatic set_c(input logic [3:0] op, input logic [1:0] m2, input logic [63:0] rs1,
                       input logic [63:0] rs2, input logic [63:0] imm, input logic [63:0] exp);
    c_if.issue_aluop    = alu_ops_t'(op);
    c_if.issue_m1_sel   = rs1_out;
    c_if.issue_m2_sel   = alu_m2_sel_t'(m2);
    c_if.issue_rs1_data = rs1;
    c_if.issue_rs2_data = rs2;
    c_if.issue_imm      = imm;
    nxt_c = '{data: exp, cyc: 0};
    c_if.issue_valid    = 1'b1;
  endtask

  task automatic next_bc();
    @(posedge clk);
    #1;
    b_if.issue_valid = 1'b0;
    c_if.issue_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    a_if.issue_valid = 1'b0; b_if.issue_valid = 1'b0; c_if.issue_valid = 1'b0;
    a_if.wb_ready = 1'b0;    b_if.wb_ready = 1'b0;    c_if.wb_ready = 1'b0;
    a_if.issue_aluop = alu_add; a_if.issue_m1_sel = rs1_out; a_if.issue_m2_sel = rs2_out;
    a_if.issue_rs1_data = '0; a_if.issue_rs2_data = '0; a_if.issue_pc = '0; a_if.issue_imm = '0;
    a_if.issue_rd_paddr = '0; a_if.issue_rob_idx = '0; a_if.issue_regf_we = 1'b0;
    b_if.issue_aluop = alu_add; b_if.issue_m1_sel = rs1_out; b_if.issue_m2_sel = rs2_out;
    b_if.issue_rs1_data = '0; b_if.issue_rs2_data = '0; b_if.issue_pc = '0; b_if.issue_imm = '0;
    b_if.issue_rd_paddr = '0; b_if.issue_rob_idx = '0; b_if.issue_regf_we = 1'b0;
    c_if.issue_aluop = alu_add; c_if.issue_m1_sel = rs1_out; c_if.issue_m2_sel = rs2_out;
    c_if.issue_rs1_data = '0; c_if.issue_rs2_data = '0; c_if.issue_pc = '0; c_if.issue_imm = '0;
    c_if.issue_rd_paddr = '0; c_if.issue_rob_idx = '0; c_if.issue_regf_we = 1'b0;
    nxt_a = '{data: '0, pc: '0, rd: '0, rob: '0, we: 1'b0, cyc: 0, chk_lat: 1'b0};
    nxt_b = '{data: '0, cyc: 0};
    nxt_c = '{data: '0, cyc: 0};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    a_if.wb_ready = 1'b1; b_if.wb_ready = 1'b1; c_if.wb_ready = 1'b1;
    @(negedge clk);
    check("rst_wb_valid", 64'(a_if.wb_valid), 64'd0);
    check("rst_occupancy", 64'(occ_a), 64'd0);
    check("rst_issue_ready", 64'(a_if.issue_ready), 64'd1);
    check("rst_c_occupancy", 64'(occ_c), 64'd0);
    @(posedge clk);
    #1;

    // add rs1=5 + imm=7, tags echoed, latency 2
    set_a(4'd0, 2'd0, 2'd1, 32'd5, 32'd0, 32'h100, 32'd7, 6'd3, 5'd7, 1'b1, 32'd12, 1'b1);
    wait_ready_a();
    idle(4);

    // back-to-back: sra, slt, sltu, sub
    set_a(4'd4, 2'd0, 2'd1, 32'h8000_0000, 32'd0, 32'h104, 32'd4, 6'd10, 5'd1, 1'b1, 32'hF800_0000, 1'b1);
    wait_ready_a();
    set_a(4'd8, 2'd0, 2'd0, 32'hFFFF_FFFF, 32'd1, 32'h108, 32'd0, 6'd11, 5'd2, 1'b1, 32'd1, 1'b1);
    wait_ready_a();
    set_a(4'd9, 2'd0, 2'd0, 32'hFFFF_FFFF, 32'd1, 32'h10C, 32'd0, 6'd12, 5'd3, 1'b0, 32'd0, 1'b1);
    wait_ready_a();
    set_a(4'd1, 2'd0, 2'd0, 32'd3, 32'd5, 32'h110, 32'd0, 6'd13, 5'd4, 1'b1, 32'hFFFF_FFFE, 1'b1);
    wait_ready_a();
    idle(4);

    // backpressure: fill with wb_ready low, then pass-through ready
    a_if.wb_ready = 1'b0;
    set_a(4'd5, 2'd0, 2'd0, 32'hF0, 32'hFF, 32'h200, 32'd0, 6'd20, 5'd8, 1'b1, 32'h0F, 1'b0);
    wait_ready_a();
    set_a(4'd6, 2'd0, 2'd0, 32'hF0, 32'h0F, 32'h204, 32'd0, 6'd21, 5'd9, 1'b1, 32'hFF, 1'b0);
    wait_ready_a();
    set_a(4'd7, 2'd0, 2'd0, 32'hF0, 32'h3C, 32'h208, 32'd0, 6'd22, 5'd10, 1'b1, 32'h30, 1'b0);
    @(negedge clk);
    check("full_issue_ready", 64'(a_if.issue_ready), 64'd0);
    check("full_occupancy", 64'(occ_a), 64'd2);
    check("full_no_wb_valid_drop", 64'(a_if.wb_valid), 64'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("full_hold_ready", 64'(a_if.issue_ready), 64'd0);
    @(posedge clk);
    #1;
    a_if.wb_ready = 1'b1;
    @(negedge clk);
    check("passthru_ready", 64'(a_if.issue_ready), 64'd1);
    @(posedge clk);
    #1;
    a_if.issue_valid = 1'b0;
    idle(4);

    // flush with two valid stages and an issue in the same cycle
    a_if.wb_ready = 1'b0;
    set_a(4'd0, 2'd0, 2'd1, 32'd1, 32'd0, 32'h300, 32'd1, 6'd30, 5'd11, 1'b1, 32'd2, 1'b0);
    wait_ready_a();
    set_a(4'd0, 2'd0, 2'd1, 32'd1, 32'd0, 32'h304, 32'd2, 6'd31, 5'd12, 1'b1, 32'd3, 1'b0);
    wait_ready_a();
    flush = 1'b1;
    a_if.wb_ready = 1'b1;
    set_a(4'd0, 2'd0, 2'd1, 32'd9, 32'd0, 32'h308, 32'd9, 6'd32, 5'd13, 1'b1, 32'd18, 1'b0);
    @(negedge clk);
    check("flush_cycle_wb_valid", 64'(a_if.wb_valid), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    a_if.issue_valid = 1'b0;
    @(negedge clk);
    check("post_flush_occupancy", 64'(occ_a), 64'd0);
    check("post_flush_wb_valid", 64'(a_if.wb_valid), 64'd0);
    check("post_flush_issue_ready", 64'(a_if.issue_ready), 64'd1);
    idle(5);

    // operand selects, wraparound, shifts and undefined opcode
    set_a(4'd0, 2'd1, 2'd2, 32'd0, 32'd0, 32'h1000, 32'd0, 6'd40, 5'd14, 1'b1, 32'h1004, 1'b1);
    wait_ready_a();
    set_a(4'hF, 2'd0, 2'd0, 32'd5, 32'd3, 32'h1004, 32'd0, 6'd41, 5'd15, 1'b1, 32'd0, 1'b1);
    wait_ready_a();
    set_a(4'd0, 2'd2, 2'd1, 32'd77, 32'd0, 32'h1008, 32'd9, 6'd42, 5'd16, 1'b0, 32'd9, 1'b1);
    wait_ready_a();
    set_a(4'd2, 2'd0, 2'd1, 32'd1, 32'd0, 32'h100C, 32'd33, 6'd43, 5'd17, 1'b1, 32'd2, 1'b1);
    wait_ready_a();
    set_a(4'd3, 2'd0, 2'd0, 32'h8000_0000, 32'd31, 32'h1010, 32'd0, 6'd44, 5'd18, 1'b1, 32'd1, 1'b1);
    wait_ready_a();
    set_a(4'd0, 2'd0, 2'd1, 32'hFFFF_FFFF, 32'd0, 32'h1014, 32'd1, 6'd45, 5'd19, 1'b1, 32'd0, 1'b1);
    wait_ready_a();
    set_a(4'd0, 2'd0, 2'd3, 32'd7, 32'd100, 32'h1018, 32'd100, 6'd46, 5'd20, 1'b1, 32'd7, 1'b1);
    wait_ready_a();
    set_a(4'd0, 2'd3, 2'd1, 32'd50, 32'd0, 32'h101C, 32'd5, 6'd47, 5'd21, 1'b1, 32'd5, 1'b1);
    wait_ready_a();
    idle(5);

    // STAGES=1 and STAGES=4/WIDTH=64 instances, back-to-back issue
    set_b(4'd0, 2'd0, 32'd2, 32'd3, 32'd0, 32'd5);
    set_c(4'd2, 2'd1, 64'd1, 64'd0, 64'd40, 64'h0000_0100_0000_0000);
    next_bc();
    set_b(4'd1, 2'd0, 32'd3, 32'd5, 32'd0, 32'hFFFF_FFFE);
    set_c(4'd2, 2'd1, 64'd1, 64'd0, 64'd104, 64'h0000_0100_0000_0000);
    next_bc();
    set_c(4'd4, 2'd1, 64'h8000_0000_0000_0000, 64'd0, 64'd40, 64'hFFFF_FFFF_FF80_0000);
    next_bc();
    set_c(4'd3, 2'd1, 64'h8000_0000_0000_0000, 64'd0, 64'd40, 64'h0000_0000_0080_0000);
    @(negedge clk);
    check("c_occupancy_3", 64'(occ_c), 64'd3);
    @(posedge clk);
    #1;
    c_if.issue_valid = 1'b0;
    set_c(4'd9, 2'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd1);
    next_bc();
    idle(10);

    check("a_queue_drained", 64'(q_a.size()), 64'd0);
    check("b_queue_drained", 64'(q_b.size()), 64'd0);
    check("c_queue_drained", 64'(q_c.size()), 64'd0);
    check("end_occupancy_b", 64'(occ_b), 64'd0);
    check("end_occupancy_c", 64'(occ_c), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_pipe_unit.md
# alu_pipe_unit

Parametrised, pipelined integer ALU functional unit for the out-of-order RV32 core. Sits between the ALU reservation station (issue side) and the CDB/writeback arbiter. Computes the result in the first stage, then carries it through a configurable-depth pipeline with full valid/ready backpressure, bubble collapse and a global flush that discards in-flight work on mispredict.

## Interface
Parameters:
- WIDTH, 32, datapath width; shift amount uses the low $clog2(WIDTH) bits of operand b.
- STAGES, 2, pipeline depth; legal range 1..4; equals issue-to-writeback latency.
- PREG_W, 6, physical register index width.
- ROB_W, 5, ROB index width.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  kill all in-flight ops (branch mispredict).
- issue_valid  in  1  reservation station presents an op.
- issue_ready  out  1  unit accepts the op this cycle.
- issue_aluop  in  4  alu_ops_t operation.
- issue_m1_sel  in  2  operand a select: rs1_out / pc_out / no_out.
- issue_m2_sel  in  2  operand b select: rs2_out / imm_out / four_out.
- issue_rs1_data, issue_rs2_data, issue_pc, issue_imm  in  WIDTH each  operand sources.
- issue_rd_paddr  in  PREG_W  destination physical register.
- issue_rob_idx  in  ROB_W  ROB tag.
- issue_regf_we  in  1  op writes a register.
- wb_valid  out  1  result available.
- wb_ready  in  1  CDB arbiter grants this cycle.
- wb_rd_data  out  WIDTH  result.
- wb_rd_paddr, wb_rob_idx, wb_regf_we, wb_pc  out  tag fields passed through unchanged.
- occupancy  out  $clog2(STAGES+1)  number of valid stages.

## Operation
- Operand a: rs1_out→rs1_data, pc_out→pc, no_out/other→0. Operand b: rs2_out→rs2_data, imm_out→imm, four_out→4, other→0.
- Ops: add, sub, sll, srl, sra (arithmetic), xor, or, and, slt (signed), sltu (unsigned); result 1/0 for compares. Undefined opcode→0. All arithmetic is modulo 2^WIDTH.
- Stage 0 registers the computed result plus tags; stages 1..STAGES-1 carry them. Stage STAGES-1 drives wb_*.
- Stage i advances when stage i+1 is empty or advancing; last stage advances when wb_ready. Bubbles collapse: an empty stage always accepts from the stage behind it.
- issue_ready = !stage0.valid || stage0 advancing; asserted regardless of issue_valid (no combinational path from issue_valid).
- Handshake: issue transfer on issue_valid && issue_ready; writeback transfer on wb_valid && wb_ready. Order is strictly preserved.
- wb_valid = last.valid && !flush.
- Flush: next cycle all valid bits 0; op issued in the flush cycle is discarded; no writeback transfer occurs in the flush cycle.
- occupancy counts valid stages after each edge; never exceeds STAGES.

## Timing
- Reset (and flush): all stage valid bits 0; wb_valid=0, occupancy=0, issue_ready=1 the following cycle. Data/tag registers need no reset; wb data fields are don't-care while wb_valid=0.
- Latency: op issued at cycle N with wb_ready held high presents wb_valid at N+STAGES.
- Throughput: one op/cycle with wb_ready high; with wb_ready low, accepts STAGES ops then issue_ready drops the cycle the unit is full.
- Full and wb_ready rises: issue_ready rises same cycle (pass-through ready), no lost slot.
- Simultaneous rst and flush: identical to reset.

## Structure
- rv32i_types: alu_ops_t (4-bit), alu_m1_sel_t, alu_m2_sel_t enums; shared with decode and reservation station.
- Sub-module alu_core: purely combinational operand mux + op evaluation, parametrised by WIDTH; reusable by the branch unit.
- Pipeline: array of STAGES stage records (valid, result, tags) with a generate loop for advance logic.

## Test plan
- Reset then issue add, rs1=5, imm=7, m2=imm_out, STAGES=2, wb_ready=1 → wb_valid at +2, wb_rd_data=12, tags echoed.
- Back-to-back sra 0x80000000>>4, slt -1<1, sltu 0xFFFFFFFF<1 → 0xF8000000, 1, 0 in order, one per cycle.
- wb_ready=0, issue 3 ops at STAGES=2 → issue_ready low after 2 accepted, occupancy=2; raise wb_ready → third accepted same cycle, order preserved.
- Flush with 2 valid stages and an issue in the same cycle → no wb_valid in flush cycle or after, occupancy=0 next cycle.
- m1=pc_out, m2=four_out, pc=0x1000 → 0x1004; undefined opcode → 0.
- Sweep STAGES=1 and 4, WIDTH=64: latency equals STAGES; shift by 40 uses 6-bit amount.
